// File: rtl/hand_track_pkg.sv
// rtl/hand_track_pkg.sv - shared widths, FSM state type and saturating add for the hand tracker
package hand_track_pkg;

   localparam int          COORD_W   = 11;
   localparam logic [10:0] COORD_MAX = 11'd2047;

   typedef enum logic [1:0] {
      ACCUM   = 2'd0,
      EVAL    = 2'd1,
      PUBLISH = 2'd2
   } track_state_t;

   // a + b on 12-bit operands, clamped to lim; the 13-bit sum cannot wrap
   function automatic logic [11:0] sat_add(input logic [11:0] a, input logic [11:0] b,
                                           input logic [11:0] lim);
      logic [12:0] s;
      s = {1'b0, a} + {1'b0, b};
      return (s > {1'b0, lim}) ? lim : s[11:0];
   endfunction

endpackage

// File: rtl/hand_presence_filter.sv
// rtl/hand_presence_filter.sv - on/off frame hysteresis producing the filtered presence flag
module hand_presence_filter
   import hand_track_pkg::*;
#(
   parameter int ON_FRAMES  = 2,
   parameter int OFF_FRAMES = 4
) (
   input  logic VGA_CLK,
   input  logic RST,
   input  logic step,
   input  logic valid,
   output logic detected,
   output logic fall
);

   logic [3:0] on_cnt;
   logic [3:0] off_cnt;
   logic [3:0] on_inc;
   logic [3:0] off_inc;

   // saturating next-count values and the falling-edge decision for this step
   always_comb begin
      on_inc  = (on_cnt  == 4'hF) ? 4'hF : on_cnt  + 4'd1;
      off_inc = (off_cnt == 4'hF) ? 4'hF : off_cnt + 4'd1;
      fall    = step & ~valid & detected & (off_inc >= 4'(OFF_FRAMES));
   end

   // advance the run counters once per closed frame and set/clear presence at the thresholds
   always_ff @(posedge VGA_CLK or posedge RST) begin
      if (RST) begin
         on_cnt   <= 4'd0;
         off_cnt  <= 4'd0;
         detected <= 1'b0;
      end else if (step) begin
         if (valid) begin
            on_cnt  <= on_inc;
            off_cnt <= 4'd0;
            if (on_inc >= 4'(ON_FRAMES)) detected <= 1'b1;
         end else begin
            off_cnt <= off_inc;
            on_cnt  <= 4'd0;
            if (off_inc >= 4'(OFF_FRAMES)) detected <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/hand_region_tracker.sv
// rtl/hand_region_tracker.sv - per-frame skin bounding box with threshold and presence hysteresis
module hand_region_tracker
   import hand_track_pkg::*;
#(
   parameter int MIN_PIXELS = 64,
   parameter int ON_FRAMES  = 2,
   parameter int OFF_FRAMES = 4,
   parameter int CNT_W      = 20
) (
   input  logic        VGA_CLK,
   input  logic        RST,
   input  logic [12:0] VGA_H_CNT,
   input  logic [12:0] VGA_V_CNT,
   input  logic        pix_valid,
   input  logic        pix_skin,
   input  logic        frame_end,
   output logic [10:0] hand_x,
   output logic [10:0] hand_y,
   output logic [10:0] hand_width,
   output logic [10:0] hand_height,
   output logic        hand_detected,
   output logic        box_update
);

   track_state_t state;
   logic [10:0]  min_x, max_x, min_y, max_y;
   logic [CNT_W-1:0] skin_cnt;
   logic         hit;
   logic         frame_valid;
   logic         step;
   logic         fall;
   logic [11:0]  width_sat, height_sat;

   // a hit is an in-range skin pixel; EVAL is where the closed frame is judged
   always_comb begin
      hit = pix_valid & pix_skin & (VGA_H_CNT[12:11] == 2'b00) & (VGA_V_CNT[12:11] == 2'b00);
      frame_valid = (skin_cnt >= CNT_W'(MIN_PIXELS));
      step = (state == EVAL);
      width_sat  = sat_add({1'b0, max_x} - {1'b0, min_x}, 12'd1, {1'b0, COORD_MAX});
      height_sat = sat_add({1'b0, max_y} - {1'b0, min_y}, 12'd1, {1'b0, COORD_MAX});
   end

   // frame sequencer; frame_end is only honoured while accumulating
   always_ff @(posedge VGA_CLK or posedge RST) begin
      if (RST) begin
         state <= ACCUM;
      end else begin
         case (state)
            ACCUM:   if (frame_end) state <= EVAL;
            EVAL:    state <= PUBLISH;
            default: state <= ACCUM;
         endcase
      end
   end

   // bounding box and pixel count; cleared as PUBLISH ends so the next frame starts fresh
   always_ff @(posedge VGA_CLK or posedge RST) begin
      if (RST) begin
         min_x    <= COORD_MAX;
         min_y    <= COORD_MAX;
         max_x    <= 11'd0;
         max_y    <= 11'd0;
         skin_cnt <= '0;
      end else if (state == PUBLISH) begin
         min_x    <= COORD_MAX;
         min_y    <= COORD_MAX;
         max_x    <= 11'd0;
         max_y    <= 11'd0;
         skin_cnt <= '0;
      end else if (state == ACCUM && hit) begin
         if (VGA_H_CNT[10:0] < min_x) min_x <= VGA_H_CNT[10:0];
         if (VGA_H_CNT[10:0] > max_x) max_x <= VGA_H_CNT[10:0];
         if (VGA_V_CNT[10:0] < min_y) min_y <= VGA_V_CNT[10:0];
         if (VGA_V_CNT[10:0] > max_y) max_y <= VGA_V_CNT[10:0];
         if (skin_cnt != '1) skin_cnt <= skin_cnt + 1'b1;
      end
   end

   hand_presence_filter #(
      .ON_FRAMES  (ON_FRAMES),
      .OFF_FRAMES (OFF_FRAMES)
   ) u_filter (
      .VGA_CLK  (VGA_CLK),
      .RST      (RST),
      .step     (step),
      .valid    (frame_valid),
      .detected (hand_detected),
      .fall     (fall)
   );

   // the box is written on the edge leaving EVAL, so it and box_update are seen during PUBLISH
   always_ff @(posedge VGA_CLK or posedge RST) begin
      if (RST) begin
         hand_x      <= 11'd0;
         hand_y      <= 11'd0;
         hand_width  <= 11'd0;
         hand_height <= 11'd0;
         box_update  <= 1'b0;
      end else begin
         box_update <= step;
         if (step) begin
            if (frame_valid) begin
               hand_x      <= min_x;
               hand_y      <= min_y;
               hand_width  <= width_sat[10:0];
               hand_height <= height_sat[10:0];
            end else if (fall) begin
               hand_x      <= 11'd0;
               hand_y      <= 11'd0;
               hand_width  <= 11'd0;
               hand_height <= 11'd0;
            end
         end
      end
   end

endmodule
